// File: rtl/stepper_pkg.sv
// Shared types and constants for the stepper move sequencer: FSM states,
// one-hot phase drive patterns and direction encoding.
package stepper_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] PH0 = 4'b0001;
    localparam logic [3:0] PH1 = 4'b0010;
    localparam logic [3:0] PH2 = 4'b0100;
    localparam logic [3:0] PH3 = 4'b1000;

    localparam logic DIR_FWD = 1'b1;
    localparam logic DIR_REV = 1'b0;

    function automatic logic [3:0] ph_decode(input logic [1:0] ph);
        logic [3:0] drv;
        case (ph)
            2'd0:    drv = PH0;
            2'd1:    drv = PH1;
            2'd2:    drv = PH2;
            default: drv = PH3;
        endcase
        return drv;
    endfunction

endpackage

// File: rtl/stepper_move_ctrl_if.sv
// Host command / status bundle for the stepper move sequencer.
// master = host side (drives commands), slave = sequencer side.
interface stepper_move_ctrl_if #(
    parameter int CNT_W = 8,
    parameter int PER_W = 8
);
    logic             start;
    logic             dir;
    logic [CNT_W-1:0] steps;
    logic [PER_W-1:0] period;
    logic             abort;
    logic             busy;
    logic             done;
    logic [3:0]       motor_drv;
    logic [1:0]       phase;
    logic [CNT_W-1:0] remaining;

    modport master (
        output start, dir, steps, period, abort,
        input  busy, done, motor_drv, phase, remaining
    );

    modport slave (
        input  start, dir, steps, period, abort,
        output busy, done, motor_drv, phase, remaining
    );
endinterface

// File: rtl/stepper_phase_seq.sv
// 2-bit rotor phase register with mod-4 up/down advance and gated one-hot drive.
// Phase updates on the edge after adv; drive is decoded from the registered phase.
module stepper_phase_seq
    import stepper_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       adv,
    input  logic       dir,
    input  logic       en,
    output logic [1:0] phase,
    output logic [3:0] drv
);

    logic [1:0] phase_q;
    logic [1:0] phase_d;

    always_comb begin
        phase_d = phase_q;
        if (adv) begin
            phase_d = (dir == DIR_FWD) ? phase_q + 2'd1 : phase_q - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= 2'd0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;
    assign drv   = en ? ph_decode(phase_q) : 4'b0000;

endmodule

// File: rtl/stepper_move_ctrl.sv
// Move sequencer: issues N full steps at a held period of max(period,1) cycles,
// first step on the cycle after an accepted start; abort ends the move without advancing.
module stepper_move_ctrl #(
    parameter int CNT_W = 8,
    parameter int PER_W = 8
) (
    input  logic                drv_clk,
    input  logic                reset,
    stepper_move_ctrl_if.slave  bus
);
    import stepper_pkg::*;

    state_t           state_q, state_d;
    logic [PER_W-1:0] cnt_q, cnt_d;
    logic [PER_W-1:0] per_q, per_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             dir_q, dir_d;
    logic             adv;
    logic             adv_dir;
    logic             tick;

    assign tick = (cnt_q == per_q - PER_W'(1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        per_d   = per_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        adv     = 1'b0;
        adv_dir = dir_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.steps != '0) begin
                        dir_d   = bus.dir;
                        per_d   = (bus.period == '0) ? PER_W'(1) : bus.period;
                        adv     = 1'b1;
                        adv_dir = bus.dir;
                        rem_d   = bus.steps - CNT_W'(1);
                        cnt_d   = '0;
                        state_d = RUN;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                cnt_d = cnt_q + PER_W'(1);
                // Abort outranks a coincident tick: remaining keeps the unissued count.
                if (bus.abort) begin
                    state_d = DONE;
                end else if (tick) begin
                    if (rem_q == '0) begin
                        state_d = DONE;
                    end else begin
                        adv   = 1'b1;
                        rem_d = rem_q - CNT_W'(1);
                        cnt_d = '0;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge drv_clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            per_q   <= PER_W'(1);
            rem_q   <= '0;
            dir_q   <= DIR_FWD;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            per_q   <= per_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
        end
    end

    stepper_phase_seq u_phase_seq (
        .clk   (drv_clk),
        .rst   (reset),
        .adv   (adv),
        .dir   (adv_dir),
        .en    (state_q == RUN),
        .phase (bus.phase),
        .drv   (bus.motor_drv)
    );

    assign bus.busy      = (state_q == RUN);
    assign bus.done      = (state_q == DONE);
    assign bus.remaining = rem_q;

endmodule

// File: tb/tb_stepper_move_ctrl.sv
// Randomized bench for stepper_move_ctrl: a per-move trace model built from step
// count, period and direction predicts every cycle's status/drive outputs.
module tb_stepper_move_ctrl;

    logic drv_clk = 1'b0;
    logic reset;

    stepper_move_ctrl_if #(.CNT_W(8), .PER_W(8)) ifc ();

    stepper_move_ctrl #(.CNT_W(8), .PER_W(8)) dut (
        .drv_clk (drv_clk),
        .reset   (reset),
        .bus     (ifc.slave)
    );

    always #5 drv_clk = ~drv_clk;

    int n_chk  = 0;
    int n_pass = 0;
    int m_phase = 0;
    int m_rem   = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (busy,done,drv,phase,rem)", tag, act, exp);
        end
    endtask

    function automatic int mod4(input int x);
        return ((x % 4) + 4) % 4;
    endfunction

    function automatic logic [31:0] pk(input bit b, input bit dn, input int ph_or_neg, input int rem);
        logic [3:0] drv;
        logic [1:0] ph;
        ph  = 2'(mod4(ph_or_neg));
        drv = b ? 4'(1 << ph) : 4'b0000;
        return {16'b0, b, dn, drv, ph, 8'(rem)};
    endfunction

    function automatic logic [31:0] obs();
        return {16'b0, ifc.busy, ifc.done, ifc.motor_drv, ifc.phase, ifc.remaining};
    endfunction

    // One move: the model unrolls it into a per-cycle trace of phase/remaining.
    task automatic do_move(input bit d, input int n, input int per,
                           input int abort_at, input int ign_at, input bit start_in_done);
        int p_eff;
        int s;
        int len;
        int p0;
        int k;
        p_eff = (per == 0) ? 1 : per;
        s     = d ? 1 : -1;
        len   = n * p_eff;
        p0    = m_phase;
        ifc.dir    = d;
        ifc.steps  = 8'(n);
        ifc.period = 8'(per);
        ifc.start  = 1'b1;
        @(posedge drv_clk); #1;
        ifc.start = 1'b0;
        for (int i = 0; i < len; i++) begin
            k = i / p_eff;
            m_phase = mod4(p0 + s * (k + 1));
            m_rem   = n - 1 - k;
            chk($sformatf("run n=%0d p=%0d cyc=%0d", n, per, i), obs(), pk(1'b1, 1'b0, m_phase, m_rem));
            if (i == abort_at) ifc.abort = 1'b1;
            if (i == ign_at) begin
                ifc.start = 1'b1;
                ifc.dir   = ~d;
                ifc.steps = 8'($urandom_range(1, 9));
            end
            @(posedge drv_clk); #1;
            ifc.abort = 1'b0;
            ifc.start = 1'b0;
            if (i == abort_at) break;
        end
        chk($sformatf("done n=%0d p=%0d", n, per), obs(), pk(1'b0, 1'b1, m_phase, m_rem));
        if (start_in_done) begin
            ifc.start = 1'b1;
            ifc.steps = 8'd3;
        end
        @(posedge drv_clk); #1;
        ifc.start = 1'b0;
        chk($sformatf("idle n=%0d p=%0d", n, per), obs(), pk(1'b0, 1'b0, m_phase, m_rem));
    endtask

    task automatic reset_mid_move();
        ifc.dir    = 1'b1;
        ifc.steps  = 8'd8;
        ifc.period = 8'd3;
        ifc.start  = 1'b1;
        @(posedge drv_clk); #1;
        ifc.start = 1'b0;
        repeat (4) @(posedge drv_clk);
        #1;
        chk("mid-move busy", obs(), pk(1'b1, 1'b0, m_phase + 2, 6));
        reset = 1'b1;
        @(posedge drv_clk); #1;
        reset = 1'b0;
        chk("reset mid-move", obs(), pk(1'b0, 1'b0, 0, 0));
        @(posedge drv_clk); #1;
        chk("after reset idle", obs(), pk(1'b0, 1'b0, 0, 0));
        m_phase = 0;
        m_rem   = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge drv_clk);
        #1;
        reset = 1'b0;
        m_phase = 0;
        m_rem   = 0;
        chk("reset state", obs(), pk(1'b0, 1'b0, 0, 0));
    endtask

    initial begin
        int n, per, len, ab, ig;
        reset      = 1'b1;
        ifc.start  = 1'b0;
        ifc.dir    = 1'b0;
        ifc.steps  = '0;
        ifc.period = '0;
        ifc.abort  = 1'b0;
        do_reset();

        do_move(1'b1, 3, 2, -1, -1, 1'b0);
        do_reset();
        do_move(1'b0, 2, 1, -1, -1, 1'b0);
        do_move(1'b1, 1, 1, -1, -1, 1'b0);
        do_move(1'b1, 5, 0, -1, -1, 1'b0);
        do_move(1'b1, 0, 3, -1, -1, 1'b0);
        do_move(1'b1, 4, 2, -1, 3, 1'b1);
        do_move(1'b1, 10, 4, 11, -1, 1'b0);
        do_move(1'b0, 0, 1, -1, -1, 1'b0);
        reset_mid_move();

        for (int r = 0; r < 40; r++) begin
            n   = $urandom_range(0, 12);
            per = $urandom_range(0, 4);
            len = n * ((per == 0) ? 1 : per);
            ab  = -1;
            ig  = -1;
            if (len > 0 && $urandom_range(0, 3) == 0) ab = $urandom_range(0, len - 1);
            if (len > 0 && $urandom_range(0, 2) == 0) ig = $urandom_range(0, len - 1);
            do_move(1'($urandom_range(0, 1)), n, per, ab, ig, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/stepper_move_ctrl.md
# stepper_move_ctrl

Move sequencer for the 4-phase unipolar stepper drive. It accepts a move command (step count, direction, step period), then issues exactly that many full steps at the commanded rate on `motor_drv`. It reports busy/done to the host, tracks the rotor phase across moves, and supports abort. It sits between the host command registers and the motor driver pins, and replaces direct host toggling of forward/reverse.

## Interface
Parameters:
- `CNT_W`, 8: width of the step count and `remaining`.
- `PER_W`, 8: width of the step period in `drv_clk` cycles.

Ports:
- `drv_clk`  in  1  clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  move request; sampled only in IDLE.
- `dir`  in  1  1 = forward (phase +1), 0 = reverse (phase −1); latched on accepted start.
- `steps`  in  CNT_W  number of steps; latched on accepted start.
- `period`  in  PER_W  cycles each phase is held; latched; 0 treated as 1.
- `abort`  in  1  terminate move; effective in RUN only.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse in DONE.
- `motor_drv`  out  4  one-hot phase drive; 0000 when not in RUN.
- `phase`  out  2  current rotor phase index.
- `remaining`  out  CNT_W  steps still to issue after the current one.

## Operation
- States: IDLE, RUN, DONE. Reset value is IDLE.
- Phase decode: 0→0001, 1→0010, 2→0100, 3→1000. Phase arithmetic is mod 4: 3+1→0 and 0−1→3.
- IDLE:
  - When `start`=1 and `steps`≠0: latch `dir` and `period` (0→1). Advance `phase` once (first step). Load `remaining`=`steps`−1 and clear the prescale counter. Go to RUN.
  - When `start`=1 and `steps`=0: go to DONE. Phase and remaining are untouched.
- RUN:
  - The prescale counter increments each cycle. The terminal count ("tick") is counter = period−1.
  - On tick: if `remaining`=0, go to DONE. Otherwise advance `phase` in the latched direction, decrement `remaining`, clear the counter, and stay in RUN.
- DONE: `done`=1 for one cycle, then go to IDLE unconditionally.
- Abort in RUN: go to DONE next cycle with no further phase advance. `remaining` holds its value so the host can read the unissued count.
- Abort and tick in the same cycle: abort wins; there is no advance and no decrement.
- `start` in RUN or DONE is ignored and not queued. `abort` in IDLE or DONE is ignored.
- `phase` persists across moves; only `reset` clears it.
- Reset at any time, including mid-move, takes effect at the next edge: IDLE, phase=0, remaining=0, counter=0, busy=0, done=0, motor_drv=0000.

## Timing
- Accepted start at edge t gives RUN from cycle t+1: busy=1 and motor_drv shows the advanced phase.
- Each phase is held for exactly P cycles, where P = max(period,1).
- A move of N≥1 steps keeps busy high for N·P cycles, and `done` pulses in cycle t+1+N·P.
- For N=0, `done` pulses in cycle t+1 and busy never rises.
- A new start is accepted at the earliest in the cycle after the `done` pulse (IDLE).
- All outputs are registered or decoded from registered state only; there is no combinational path from inputs to outputs.

## Structure
- Package `stepper_pkg`:
  - state encoding constants: IDLE, RUN, DONE.
  - phase one-hot constants: PH0..PH3.
  - direction constants: DIR_FWD=1, DIR_REV=0.
- Sub-module `stepper_phase_seq`:
  - contents: 2-bit phase register with synchronous reset, `adv` and `dir` inputs (mod-4 up/down), and one-hot decode gated by an `en` input.
  - instantiation: `stepper_move_ctrl` instantiates it once.
- The top level holds the FSM, the prescale counter, the remaining counter and the command latches.

## Test plan
- After reset, forward, steps=3, period=2, start at t → motor_drv 0010 for t+1..t+2, 0100 for t+3..t+4, 1000 for t+5..t+6; done=1 at t+7; phase=3; busy low at t+7.
- From phase 0, reverse, steps=2, period=1 → motor_drv 1000 at t+1, 0100 at t+2; done at t+3; phase=2.
- Wrap: from phase 3, forward, steps=5, period=0 (treated as 1) → phases 0,1,2,3,0 on consecutive cycles; done at t+6.
- steps=0 → done at t+1; busy stays 0; phase unchanged. A start pulsed during a running move is ignored; after done the phase equals only the first move's result.
- forward, steps=10, period=4; abort coincident with the 3rd tick → no advance at that tick; done the next cycle; remaining=7; motor_drv=0000 in DONE.
- reset asserted mid-move → next cycle IDLE: motor_drv=0000, phase=0, remaining=0, busy=0, no done pulse.
